// File: rtl/risc_v.sv
// Single-cycle RV32I-subset core: fetch, decode, execute, memory and writeback
// all resolve combinationally from PC, and each rising edge retires one instruction.

module imem (
  input  logic [7:0]  addr,
  output logic [31:0] rdata
);
  // Preloaded hierarchically before run; indexed by the raw byte address.
  logic [31:0] mem [0:255];

  assign rdata = mem[addr];
endmodule

module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  // x0 is an ordinary register here, not tied to zero.
  logic [31:0] mem [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
endmodule

module dmem (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  // Word-wide, word-indexed; contents survive reset.
  logic [31:0] mem [0:255];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

module datapath (
  input logic clk,
  input logic rst
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr;
  logic [31:0] rs1_val, rs2_val, dm_rdata;
  logic [31:0] rf_wdata, imm_i, imm_b;
  logic        rf_we, dm_we;
  logic [7:0]  dm_addr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (f3)
      3'd0: r = alt ? (a - b) : (a + b);
      3'd1: r = a << b[4:0];
      3'd2: r = {31'b0, $signed(a) < $signed(b)};
      3'd3: r = {31'b0, a < b};
      3'd4: r = a ^ b;
      3'd5: begin
        if (alt) r = $signed(a) >>> b[4:0];
        else     r = a >> b[4:0];
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  imem IMEM_call (.addr(pc_q[7:0]), .rdata(instr));

  regfile Reg_call (
    .clk(clk), .rst(rst), .we(rf_we), .waddr(rd), .wdata(rf_wdata),
    .raddr1(rs1), .raddr2(rs2), .rdata1(rs1_val), .rdata2(rs2_val)
  );

  // Writes are suppressed while reset is held so an aborted store cannot land.
  dmem DMEM_call (
    .clk(clk), .we(dm_we & rst), .addr(dm_addr), .wdata(rs2_val), .rdata(dm_rdata)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  // Only the low 8 bits of the effective address matter, so add at that width.
  assign dm_addr = rs1_val[7:0] + ((opcode == OP_STORE) ? {instr[27:25], instr[11:7]}
                                                        : instr[27:20]);

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = '0;
    dm_we    = 1'b0;
    pc_d     = pc_q + 32'd4;
    case (opcode)
      OP_LUI: begin
        rf_we    = 1'b1;
        rf_wdata = {12'b0, instr[31:12]};
      end
      OP_IMM: begin
        rf_we    = 1'b1;
        rf_wdata = alu(funct3, (funct3 == 3'd5) && instr[30], rs1_val, imm_i);
      end
      OP_REG: begin
        rf_we    = 1'b1;
        rf_wdata = alu(funct3, ((funct3 == 3'd0) || (funct3 == 3'd5)) && instr[30],
                       rs1_val, rs2_val);
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          rf_we    = 1'b1;
          rf_wdata = dm_rdata;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) dm_we = 1'b1;
      end
      OP_BRANCH: begin
        if ((funct3 == 3'b000 && rs1_val == rs2_val) ||
            (funct3 == 3'b001 && rs1_val != rs2_val))
          pc_d = pc_q + imm_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= '0;
    else      pc_q <= pc_d;
  end
endmodule

module risc_v (
  input logic clk,
  input logic rst
);
  datapath dtpath (.clk(clk), .rst(rst));
endmodule

// File: tb/tb_risc_v.sv
// Directed-program bench for risc_v: loads IMEM hierarchically, steps edges and
// checks register file, DMEM and PC against hand-computed values.

module tb_risc_v;
  logic clk;
  logic rst;
  int   nchk;
  int   nerr;

  risc_v dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic ld(input int a, input logic [31:0] w);
    dut.dtpath.IMEM_call.mem[a] = w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [4:0] rd);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  initial begin
    int nz;
    nchk = 0;
    nerr = 0;
    clk  = 1'b0;
    rst  = 1'b1;

    for (int i = 0; i < 256; i++) ld(i, 32'h0);
    ld('h00, 32'h00039037);
    ld('h04, 32'h000030B7);
    ld('h08, 32'h00015137);
    ld('h0C, 32'h000101B7);
    ld('h10, 32'h00A08213);
    ld('h14, 32'h000202B3);
    ld('h18, 32'h00312123);
    ld('h1C, 32'h00212083);
    ld('h20, enc_b(13'd8, 5'd0, 5'd0, 3'b000));        // beq x0,x0,+8
    ld('h24, enc_i(12'd1, 5'd0, 3'b000, 5'd9));        // addi x9,x0,1 (skipped)
    ld('h28, enc_b(13'd8, 5'd0, 5'd0, 3'b001));        // bne x0,x0,+8
    ld('h2C, enc_u(20'd3, 5'd1));                      // lui x1,3
    ld('h30, enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd6));  // sub x6,x1,x2
    ld('h34, enc_r(7'h00, 5'd1, 5'd6, 3'b010, 5'd10)); // slt x10,x6,x1
    ld('h38, enc_r(7'h00, 5'd1, 5'd6, 3'b011, 5'd11)); // sltu x11,x6,x1
    ld('h3C, enc_i(12'h401, 5'd6, 3'b101, 5'd7));      // srai x7,x6,1
    ld('h40, enc_i(12'hFFC, 5'd1, 3'b000, 5'd8));      // addi x8,x1,-4
    ld('h44, enc_u(20'h100, 5'd12));                   // lui x12,0x100
    ld('h48, enc_s(12'h017, 5'd6, 5'd12));             // sw x6,0x17(x12)
    ld('h4C, enc_lw(12'h017, 5'd12, 5'd14));           // lw x14,0x17(x12)
    // 0x50 stays all-zero: illegal opcode

    #2 rst = 1'b0;
    #1;
    chk("rst_pc", dut.dtpath.pc_q, 32'h0);
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.dtpath.Reg_call.mem[i] !== 32'h0) nz++;
    chk("rst_regs_nonzero", nz, 0);
    @(negedge clk);
    rst = 1'b1;

    step(); chk("base_x0", dut.dtpath.Reg_call.mem[0], 32'd57);
    step(); chk("base_x1", dut.dtpath.Reg_call.mem[1], 32'd3);
    step(); chk("base_x2", dut.dtpath.Reg_call.mem[2], 32'd21);
    step(); chk("base_x3", dut.dtpath.Reg_call.mem[3], 32'd16);
    step(); chk("base_x4", dut.dtpath.Reg_call.mem[4], 32'd13);
    step(); chk("base_x5", dut.dtpath.Reg_call.mem[5], 32'd70);
    step(); chk("base_dmem23", dut.dtpath.DMEM_call.mem[23], 32'd16);
    step(); chk("base_lw_x1", dut.dtpath.Reg_call.mem[1], 32'd16);

    step(); chk("beq_taken_pc", dut.dtpath.pc_q, 32'h28);
    step(); chk("bne_fall_pc", dut.dtpath.pc_q, 32'h2C);
    chk("beq_skip_x9", dut.dtpath.Reg_call.mem[9], 32'h0);
    step(); chk("lui_x1", dut.dtpath.Reg_call.mem[1], 32'd3);
    step(); chk("sub_x6", dut.dtpath.Reg_call.mem[6], 32'hFFFFFFEE);
    step(); chk("slt_x10", dut.dtpath.Reg_call.mem[10], 32'd1);
    step(); chk("sltu_x11", dut.dtpath.Reg_call.mem[11], 32'd0);
    step(); chk("srai_x7", dut.dtpath.Reg_call.mem[7], 32'hFFFFFFF7);
    step(); chk("addi_x8", dut.dtpath.Reg_call.mem[8], 32'hFFFFFFFF);
    chk("pc_before_rst", dut.dtpath.pc_q, 32'h44);

    // Mid-program reset between edges, then hold it across an edge.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_pc", dut.dtpath.pc_q, 32'h0);
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.dtpath.Reg_call.mem[i] !== 32'h0) nz++;
    chk("mid_rst_regs_nonzero", nz, 0);
    chk("mid_rst_dmem23", dut.dtpath.DMEM_call.mem[23], 32'd16);
    step();
    chk("held_rst_x0", dut.dtpath.Reg_call.mem[0], 32'h0);
    chk("held_rst_pc", dut.dtpath.pc_q, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("restart_x0", dut.dtpath.Reg_call.mem[0], 32'd57);
    chk("restart_pc", dut.dtpath.pc_q, 32'h4);
    repeat (15) step();
    chk("rerun_pc", dut.dtpath.pc_q, 32'h44);
    chk("rerun_x6", dut.dtpath.Reg_call.mem[6], 32'hFFFFFFEE);

    step(); chk("lui_x12", dut.dtpath.Reg_call.mem[12], 32'h100);
    step(); chk("sw_wrap_dmem17", dut.dtpath.DMEM_call.mem[8'h17], 32'hFFFFFFEE);
    step(); chk("lw_wrap_x14", dut.dtpath.Reg_call.mem[14], 32'hFFFFFFEE);

    step();
    chk("illegal_pc", dut.dtpath.pc_q, 32'h54);
    chk("illegal_x0", dut.dtpath.Reg_call.mem[0], 32'd57);
    chk("illegal_x14", dut.dtpath.Reg_call.mem[14], 32'hFFFFFFEE);
    chk("illegal_dmem17", dut.dtpath.DMEM_call.mem[8'h17], 32'hFFFFFFEE);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/risc_v.md
# risc_v

Single-cycle 32-bit RV32I-subset processor core with no external data ports. Instruction memory, register file and data memory are internal, and testbenches observe them hierarchically. Each rising clock edge retires exactly one instruction. It is the top level of the CPU design and contains one datapath instance.

## Interface
- No parameters.
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- No output ports.
- Fixed hierarchy, accessed by benches:
  - dtpath.IMEM_call.mem: instruction ROM, 32-bit × 256.
  - dtpath.Reg_call.mem: register file, 32-bit × 32.
  - dtpath.DMEM_call.mem: data RAM, 32-bit × 256.
- IMEM is loaded with $readmemh before run; benches use byte addresses as array indices (entries 0, 4, 8, …).

## Operation
- **Fetch:** instr = IMEM.mem[PC[7:0]]. PC is a 32-bit byte address and advances by 4. IMEM is indexed directly by PC, so only every 4th entry is used.
- **Decode:** standard RV32I field positions.
- **Register file:**
  - Two combinational read ports, one write port.
  - x0 is an ordinary writable register, not hardwired to zero.
- **Supported instructions:**
  - LUI (0110111): rd = zero-extended instr[31:12], not shifted. Non-standard; e.g. lui x1,3 gives x1 = 3.
  - OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI. Immediate is sign-extended instr[31:20]. Shift amount is instr[24:20].
  - OP (0110011): ADD, SUB (funct7 = 0100000), SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Shift amount is rs2[4:0].
  - LW (0000011, funct3 = 010): rd = DMEM.mem[(rs1 + simm)[7:0]].
  - SW (0100011, funct3 = 010): DMEM.mem[(rs1 + simm)[7:0]] = rs2. Immediate is {instr[31:25], instr[11:7]} sign-extended.
  - BEQ / BNE (1100011): if taken, PC = PC + sign-extended B-immediate; otherwise PC + 4.
- **Data memory addressing:**
  - DMEM is word-wide and word-indexed. The effective address indexes the array directly; no byte lanes, no alignment check, no >>2.
  - Address bits above [7:0] are ignored (wrap).
- **Arithmetic:** all 32-bit with modulo-2^32 wrap. SLT is signed; SLTU is unsigned.
- **Unsupported or illegal opcodes:**
  - Execute as no-ops: no register or memory write, PC + 4.
  - Unsupported funct3 under a supported opcode is also a no-op.

## Timing
- **Single cycle:** decode, ALU, register reads and DMEM read are combinational from PC.
- **Rising edge of clk, when rst = 1:**
  - PC updates.
  - Register write occurs if enabled.
  - DMEM write occurs if enabled.
- **Visibility:**
  - A result is visible in the register file or DMEM immediately after the edge that retires its instruction.
  - The next instruction reads the updated value; no hazards exist.
- **Reset behaviour:**
  - rst = 0 asynchronously forces PC = 0 and clears all 32 registers to 0.
  - Reset has no effect on DMEM or IMEM contents.
  - Reset asserted mid-run aborts the current instruction; no write from it occurs on later edges while reset is held.
  - After release, the first rising edge executes IMEM[0].
- **No outputs**, so there are no output reset values. Observation is through hierarchy only.
- **Same-edge write and read:** an instruction reading a register written on the same edge sees the old value until the edge completes, as in standard flop behaviour.

## Test plan
- **Baseline program.** Load IMEM @0 39037, @4 30B7, @8 15137, @C 101B7, @10 A08213, @14 202B3, @18 312123, @1C 212083. Release reset, then apply 8 edges. Required after the respective edges:
  - x0 = 57, x1 = 3, x2 = 21, x3 = 16.
  - x4 = 13, x5 = 70 (x0 is not zero).
  - DMEM[23] = 16, then x1 = 16.
- **R-type and immediates.**
  - SUB x6,x1,x2 with x1 = 3, x2 = 21 gives x6 = 0xFFFFFFEE.
  - SLT gives 1, SLTU gives 0.
  - SRAI x7,x6,1 gives 0xFFFFFFF7.
  - ADDI x8,x1,-4 gives 0xFFFFFFFF.
- **Branches.**
  - BEQ with equal operands and offset 8 skips one instruction: PC goes 0x20 → 0x28.
  - BNE with equal operands falls through to PC + 4.
- **Memory wrap.** SW with rs1 + imm = 0x117 writes DMEM[0x17]. LW from the same address returns the stored value.
- **Reset.**
  - Assert rst = 0 mid-program, between edges. PC and registers clear immediately, and DMEM[23] retains 16.
  - After release, execution restarts from IMEM[0].
- **Illegal opcode.** An all-zero word at PC leaves registers and DMEM unchanged, and PC advances by 4.
